// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_sequencer_pkg;

   // Fetch-stage PC mux select codes (2'b11 is never driven)
   localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
   localparam logic [1:0] PCSEL_BRANCH = 2'b01;
   localparam logic [1:0] PCSEL_JUMP   = 2'b10;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_BOOT     = 2'b00,
      ST_RUN      = 2'b01,
      ST_WAIT_MEM = 2'b10,
      ST_ERROR    = 2'b11
   } state_t;

   // Jump wins over a same-cycle branch
   function automatic logic [1:0] redirect_code(input logic jump);
      return jump ? PCSEL_JUMP : PCSEL_BRANCH;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake and redirect signals between decode/hazard logic, fetch stage
// and the fetch sequencer.
interface fetch_sequencer_if;

   logic        BranchTakenD;
   logic        JumpD;
   logic [31:0] PcBranchD;
   logic [31:0] PcJumpD;
   logic        StallD;
   logic        ImemReadyF;
   logic        ImemReqF;
   logic        PcEnF;
   logic [1:0]  PcScrF;
   logic [31:0] PcBranchF;
   logic [31:0] PcJumpF;
   logic        FlushD;
   logic        TimeoutErr;
   logic        Busy;

   // Sequencer view
   modport master (
      input  BranchTakenD, JumpD, PcBranchD, PcJumpD, StallD, ImemReadyF,
      output ImemReqF, PcEnF, PcScrF, PcBranchF, PcJumpF, FlushD,
      TimeoutErr, Busy
   );

   // Surrounding pipeline view
   modport slave (
      output BranchTakenD, JumpD, PcBranchD, PcJumpD, StallD, ImemReadyF,
      input  ImemReqF, PcEnF, PcScrF, PcBranchF, PcJumpF, FlushD,
      TimeoutErr, Busy
   );

endinterface

// File: rtl/fetch_sequencer_redirect_latch.sv
// Holds a redirect that arrived while instruction memory was busy, and
// selects which targets are presented to the fetch-stage mux.
module redirect_latch
   import fetch_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        set,
   input  logic        clr,
   input  logic        bypass,
   input  logic [1:0]  set_code,
   input  logic [31:0] set_target,
   input  logic [31:0] branch_in,
   input  logic [31:0] jump_in,
   output logic        pending,
   output logic [1:0]  pend_code,
   output logic [31:0] branch_out,
   output logic [31:0] jump_out
);

   logic [31:0] pend_target;
   logic        use_stored;

   // Pending register: set (or overwrite) takes priority over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= 1'b0;
         pend_code   <= PCSEL_PLUS4;
         pend_target <= '0;
      end else if (set) begin
         pending     <= 1'b1;
         pend_code   <= set_code;
         pend_target <= set_target;
      end else if (clr) begin
         pending     <= 1'b0;
         pend_code   <= PCSEL_PLUS4;
      end
   end

   // A live redirect this cycle always sees its own targets, even if an
   // older one is still pending
   always_comb begin
      use_stored = pending && !bypass;
      branch_out = use_stored ? pend_target : branch_in;
      jump_out   = use_stored ? pend_target : jump_in;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: boot hold, PC select/enable, F/D flush, waiting on a
// multi-cycle instruction memory, and a sticky memory-timeout error.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned CW          = 8
)(
   input  logic              CLK,
   input  logic              Reset,
   fetch_sequencer_if.master bus
);

   localparam logic [CW-1:0] BOOT_LAST    = CW'(BOOT_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_next;
   // BOOT and WAIT_MEM never overlap, so one counter serves both
   logic [CW-1:0] cnt, cnt_next;
   logic          redirect;
   logic [1:0]    live_code;
   logic [31:0]   live_target;
   logic          pc_en;
   logic [1:0]    pc_scr;
   logic          flush;
   logic          latch_set;
   logic          latch_clr;
   logic          pending;
   logic [1:0]    pend_code;

   // State and counter registers
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= ST_BOOT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Decode the live redirect request; a stall masks it entirely
   always_comb begin
      redirect    = !bus.StallD && (bus.JumpD || bus.BranchTakenD);
      live_code   = redirect_code(bus.JumpD);
      live_target = bus.JumpD ? bus.PcJumpD : bus.PcBranchD;
   end

   // Next-state, counter and PC-control decisions
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pc_en      = 1'b0;
      pc_scr     = PCSEL_PLUS4;
      flush      = 1'b0;
      latch_set  = 1'b0;
      latch_clr  = 1'b0;
      case (state)
         ST_BOOT: begin
            flush = 1'b1;
            if (cnt == BOOT_LAST) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         ST_RUN: begin
            if (bus.StallD) begin
               // hold PC; decode keeps its redirect until the stall clears
            end else if (!bus.ImemReadyF) begin
               state_next = ST_WAIT_MEM;
               cnt_next   = '0;
               latch_set  = redirect;
               flush      = redirect;
            end else if (redirect) begin
               pc_en  = 1'b1;
               pc_scr = live_code;
               flush  = 1'b1;
            end else begin
               pc_en = 1'b1;
            end
         end
         ST_WAIT_MEM: begin
            if (!bus.ImemReadyF) begin
               flush = redirect;
               if (cnt == TIMEOUT_LAST) begin
                  state_next = ST_ERROR;
                  latch_clr  = 1'b1;
               end else begin
                  cnt_next  = cnt + CW'(1);
                  latch_set = redirect;
               end
            end else if (!bus.StallD) begin
               pc_en      = 1'b1;
               state_next = ST_RUN;
               latch_clr  = 1'b1;
               if (redirect) begin
                  pc_scr = live_code;
                  flush  = 1'b1;
               end else if (pending) begin
                  pc_scr = pend_code;
                  flush  = 1'b1;
               end
            end
            // ready while stalled: data not consumed, counter frozen
         end
         ST_ERROR: begin
            flush = 1'b1;
         end
      endcase
   end

   redirect_latch u_redirect_latch (
      .clk        (CLK),
      .rst_n      (Reset),
      .set        (latch_set),
      .clr        (latch_clr),
      .bypass     (redirect),
      .set_code   (live_code),
      .set_target (live_target),
      .branch_in  (bus.PcBranchD),
      .jump_in    (bus.PcJumpD),
      .pending    (pending),
      .pend_code  (pend_code),
      .branch_out (bus.PcBranchF),
      .jump_out   (bus.PcJumpF)
   );

   // Request depends on state only, never on ImemReadyF
   assign bus.ImemReqF   = (state == ST_RUN) || (state == ST_WAIT_MEM);
   assign bus.PcEnF      = pc_en;
   assign bus.PcScrF     = pc_scr;
   assign bus.FlushD     = flush;
   assign bus.TimeoutErr = (state == ST_ERROR);
   assign bus.Busy       = (state == ST_BOOT) || (state == ST_WAIT_MEM);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner
// sequences, and random stimulus checked against a behavioural model.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int unsigned BOOT = 4;
   localparam int unsigned TO   = 255;

   logic CLK = 1'b0;
   logic Reset;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.BOOT_CYCLES(BOOT), .TIMEOUT(TO), .CW(8)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic chks(input string name, input logic [1:0] act, input logic [1:0] exp);
      chk(name, {30'b0, act}, {30'b0, exp});
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [1:0]  code;
      logic [31:0] tgt;
   } redir_t;

   redir_t      pend_q[$];
   int unsigned m_boot_left   = 0;
   int unsigned m_wait_cycles = 0;
   bit          m_waiting     = 1'b0;
   bit          m_err         = 1'b0;

   task automatic model_check(input string tag);
      logic e_req, e_en, e_fl, e_err, e_busy;
      logic [1:0]  e_scr, code;
      logic [31:0] e_pb, e_pj, tgt;
      bit redir;
      redir_t r;
      redir = !bus.StallD && (bus.JumpD || bus.BranchTakenD);
      code  = bus.JumpD ? PCSEL_JUMP : PCSEL_BRANCH;
      tgt   = bus.JumpD ? bus.PcJumpD : bus.PcBranchD;
      r.code = code;
      r.tgt  = tgt;
      e_req = 1'b0; e_en = 1'b0; e_fl = 1'b0; e_err = 1'b0; e_busy = 1'b0;
      e_scr = PCSEL_PLUS4;
      if (!Reset) begin
         m_boot_left = BOOT;
         m_waiting   = 1'b0;
         m_err       = 1'b0;
         pend_q.delete();
      end
      if (pend_q.size() != 0 && !redir) begin
         e_pb = pend_q[0].tgt;
         e_pj = pend_q[0].tgt;
      end else begin
         e_pb = bus.PcBranchD;
         e_pj = bus.PcJumpD;
      end
      if (!Reset) begin
         e_fl = 1'b1; e_busy = 1'b1;
      end else if (m_err) begin
         e_fl = 1'b1; e_err = 1'b1;
      end else if (m_boot_left > 0) begin
         e_fl = 1'b1; e_busy = 1'b1;
         m_boot_left--;
      end else if (!m_waiting) begin
         e_req = 1'b1;
         if (bus.StallD) begin
         end else if (!bus.ImemReadyF) begin
            e_fl = redir;
            if (redir) pend_q.push_back(r);
            m_waiting     = 1'b1;
            m_wait_cycles = 0;
         end else begin
            e_en = 1'b1;
            if (redir) begin e_fl = 1'b1; e_scr = code; end
         end
      end else begin
         e_req = 1'b1; e_busy = 1'b1;
         if (!bus.ImemReadyF) begin
            e_fl = redir;
            if (redir) begin pend_q.delete(); pend_q.push_back(r); end
            m_wait_cycles++;
            if (m_wait_cycles == TO) begin
               m_err     = 1'b1;
               m_waiting = 1'b0;
               pend_q.delete();
            end
         end else if (!bus.StallD) begin
            e_en = 1'b1;
            if (redir) begin
               e_fl = 1'b1; e_scr = code;
            end else if (pend_q.size() != 0) begin
               e_fl = 1'b1; e_scr = pend_q[0].code;
            end
            pend_q.delete();
            m_waiting = 1'b0;
         end
      end
      chkb({tag, " ImemReqF"},   bus.ImemReqF,   e_req);
      chkb({tag, " PcEnF"},      bus.PcEnF,      e_en);
      chks({tag, " PcScrF"},     bus.PcScrF,     e_scr);
      chkb({tag, " FlushD"},     bus.FlushD,     e_fl);
      chkb({tag, " TimeoutErr"}, bus.TimeoutErr, e_err);
      chkb({tag, " Busy"},       bus.Busy,       e_busy);
      chk ({tag, " PcBranchF"},  bus.PcBranchF,  e_pb);
      chk ({tag, " PcJumpF"},    bus.PcJumpF,    e_pj);
   endtask

   // Drive one cycle's inputs after the falling edge, then check outputs
   task automatic apply(input logic rst, input logic stall, input logic b, input logic j,
                        input logic [31:0] pb, input logic [31:0] pj, input logic rdy,
                        input string tag);
      @(negedge CLK);
      Reset            = rst;
      bus.StallD       = stall;
      bus.BranchTakenD = b;
      bus.JumpD        = j;
      bus.PcBranchD    = pb;
      bus.PcJumpD      = pj;
      bus.ImemReadyF   = rdy;
      #1;
      model_check(tag);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        stall, b, j, rdy;
      logic [31:0] pb, pj;
      logic        en;
      logic [1:0]  scr;
      logic        fl, busy;
      logic [31:0] xpb, xpj;
   } vec_t;

   vec_t vt [21];

   initial begin
      //          stall  b     j     rdy   pb        pj         en    scr    fl    busy  xpb       xpj
      vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40,   32'h0,     1'b1, 2'b01, 1'b1, 1'b0, 32'h40,   32'h0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h80,   32'h200,   1'b1, 2'b10, 1'b1, 1'b0, 32'h80,   32'h200};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h60,   32'h0,     1'b0, 2'b00, 1'b0, 1'b0, 32'h60,   32'h0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h60,   32'h0,     1'b0, 2'b00, 1'b0, 1'b0, 32'h60,   32'h0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,     1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,     1'b0, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h44,   32'h0,     1'b0, 2'b00, 1'b1, 1'b0, 32'h44,   32'h0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,     1'b0, 2'b00, 1'b0, 1'b1, 32'h44,   32'h44};
      vt[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b01, 1'b1, 1'b1, 32'h44,   32'h44};
      vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,     1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0};
      vt[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10,   32'h0,     1'b0, 2'b00, 1'b1, 1'b1, 32'h10,   32'h0};
      vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    32'h20,    1'b0, 2'b00, 1'b1, 1'b1, 32'h0,    32'h20};
      vt[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,     1'b0, 2'b00, 1'b0, 1'b1, 32'h20,   32'h20};
      vt[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h30,   32'h0,     1'b1, 2'b01, 1'b1, 1'b1, 32'h30,   32'h0};
      vt[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h5,     1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    32'h5};

      Reset = 1'b0;
      bus.StallD = 1'b0; bus.BranchTakenD = 1'b0; bus.JumpD = 1'b0;
      bus.PcBranchD = '0; bus.PcJumpD = '0; bus.ImemReadyF = 1'b1;

      // Reset held 3 cycles
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, $sformatf("rst%0d", i));
         chkb("reset PcEnF",    bus.PcEnF,    1'b0);
         chkb("reset FlushD",   bus.FlushD,   1'b1);
         chkb("reset ImemReqF", bus.ImemReqF, 1'b0);
         chkb("reset Busy",     bus.Busy,     1'b1);
         chks("reset PcScrF",   bus.PcScrF,   2'b00);
      end

      // Boot hold: request and PC load start at cycle BOOT
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, $sformatf("boot%0d", i));
         chkb($sformatf("boot%0d PcEnF", i),    bus.PcEnF,    i >= 4);
         chkb($sformatf("boot%0d ImemReqF", i), bus.ImemReqF, i >= 4);
      end

      // Directed table
      for (int i = 0; i < 21; i++) begin
         apply(1'b1, vt[i].stall, vt[i].b, vt[i].j, vt[i].pb, vt[i].pj, vt[i].rdy,
               $sformatf("vec%0d", i));
         chkb($sformatf("vec%0d PcEnF", i),     bus.PcEnF,     vt[i].en);
         chks($sformatf("vec%0d PcScrF", i),    bus.PcScrF,    vt[i].scr);
         chkb($sformatf("vec%0d FlushD", i),    bus.FlushD,    vt[i].fl);
         chkb($sformatf("vec%0d Busy", i),      bus.Busy,      vt[i].busy);
         chkb($sformatf("vec%0d ImemReqF", i),  bus.ImemReqF,  1'b1);
         chk ($sformatf("vec%0d PcBranchF", i), bus.PcBranchF, vt[i].xpb);
         chk ($sformatf("vec%0d PcJumpF", i),   bus.PcJumpF,   vt[i].xpj);
      end

      // Jump arriving in wait cycle 2 is replayed when memory becomes ready
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, "jw0");
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, "jw1");
      apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 1'b0, "jw2");
      chkb("jw2 FlushD", bus.FlushD, 1'b1);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, "jw3");
      chk ("jw3 PcJumpF", bus.PcJumpF, 32'h100);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, "jw4");
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, "jw5");
      chkb("jw5 PcEnF",   bus.PcEnF,   1'b1);
      chks("jw5 PcScrF",  bus.PcScrF,  2'b10);
      chkb("jw5 FlushD",  bus.FlushD,  1'b1);
      chk ("jw5 PcJumpF", bus.PcJumpF, 32'h100);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, "jw6");
      chks("jw6 PcScrF",  bus.PcScrF,  2'b00);
      chk ("jw6 PcJumpF", bus.PcJumpF, 32'h0);

      // Reset mid-wait drops the pending redirect
      apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 1'b0, "rp0");
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, "rp1");
      chkb("rp1 FlushD",    bus.FlushD,    1'b1);
      chkb("rp1 ImemReqF",  bus.ImemReqF,  1'b0);
      chk ("rp1 PcBranchF", bus.PcBranchF, 32'h0);
      for (int i = 0; i < 4; i++)
         apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, $sformatf("rpb%0d", i));
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "rp2");
      chkb("rp2 PcEnF",  bus.PcEnF,  1'b1);
      chks("rp2 PcScrF", bus.PcScrF, 2'b00);
      chkb("rp2 FlushD", bus.FlushD, 1'b0);

      // Memory timeout: RUN cycle plus TO wait cycles, then sticky error
      for (int k = 0; k < 260; k++) begin
         apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $sformatf("to%0d", k));
         if (k == 255) chkb("to255 TimeoutErr", bus.TimeoutErr, 1'b0);
         if (k == 256) begin
            chkb("to256 TimeoutErr", bus.TimeoutErr, 1'b1);
            chkb("to256 ImemReqF",   bus.ImemReqF,   1'b0);
         end
      end
      apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 1'b1, "tos");
      chkb("sticky TimeoutErr", bus.TimeoutErr, 1'b1);
      chkb("sticky PcEnF",      bus.PcEnF,      1'b0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "tor");
      chkb("clr TimeoutErr", bus.TimeoutErr, 1'b0);
      chkb("clr Busy",       bus.Busy,       1'b1);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "tor2");

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         apply($urandom_range(0, 99) != 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0,
               $urandom, $urandom,
               $urandom_range(0, 9) < 6,
               $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block for the fetch stage. Drives the fetch stage's PC-select (PcScrF) and PC load enable (stallF input, 1 = load), and flushes the F/D pipeline register on a redirect. Handles a multi-cycle instruction memory with a ready handshake, and latches a branch/jump redirect that arrives while memory is busy. Adds a post-reset boot hold and a memory-timeout watchdog. Sits between the hazard/decode logic and the fetch stage.

Parameters:
BOOT_CYCLES, 4, cycles the PC is held after reset release before the first fetch request
TIMEOUT, 255, max consecutive not-ready cycles before the sticky error
CW, 8, width of the boot and wait counters (must hold max(BOOT_CYCLES, TIMEOUT))

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous reset, active-low
BranchTakenD  in  1  branch resolved taken in decode
JumpD  in  1  jump in decode
PcBranchD  in  32  branch target
PcJumpD  in  32  jump target
StallD  in  1  hazard-unit stall request
ImemReadyF  in  1  instruction memory has valid data for the current PC
ImemReqF  out  1  fetch request to instruction memory
PcEnF  out  1  PC load enable to the fetch stage (1 = load)
PcScrF  out  2  PC mux select: 00 PC+4, 01 branch, 10 jump; 11 never driven
PcBranchF  out  32  branch target to the fetch mux
PcJumpF  out  32  jump target to the fetch mux
FlushD  out  1  clear the F/D register this cycle
TimeoutErr  out  1  sticky memory-timeout flag
Busy  out  1  1 in BOOT or WAIT_MEM

Behaviour:
- States: BOOT, RUN, WAIT_MEM, ERROR. Encoding is 2 bits.
- Reset asserted (Reset=0, async):
  - state=BOOT, counters=0, pending cleared, TimeoutErr=0.
  - Outputs: PcEnF=0, PcScrF=00, FlushD=1, ImemReqF=0, Busy=1.
  - Reset asserted mid-operation behaves identically and drops any pending redirect.
- BOOT:
  - PcEnF=0, ImemReqF=0, FlushD=1.
  - Counter increments each cycle. When it reaches BOOT_CYCLES-1, go to RUN. First request is therefore issued BOOT_CYCLES cycles after reset release.
- RUN: ImemReqF=1. Priority order, evaluated each cycle:
  1. StallD=1: PcEnF=0, FlushD=0, PcScrF=00. Redirect inputs are ignored; the hazard unit guarantees decode redirects are held until the stall releases.
  2. ImemReadyF=0: PcEnF=0, go to WAIT_MEM, wait counter cleared. A redirect present this cycle is latched into pending (select code and target), and FlushD=1 this cycle.
  3. Redirect with ready: PcEnF=1 and FlushD=1 in the same cycle. JumpD has priority over BranchTakenD (PcScrF=10), otherwise 01.
  4. Otherwise: PcEnF=1, PcScrF=00, FlushD=0.
- WAIT_MEM:
  - PcEnF=0, ImemReqF=1, Busy=1. Wait counter increments.
  - A new redirect (StallD=0) overwrites pending; jump wins a same-cycle tie. FlushD=1 on any cycle a redirect is latched.
  - On ImemReadyF=1:
    - If a live redirect is present, it overrides pending.
    - Else, if pending is set, use pending: PcEnF=1, PcScrF=its code, FlushD=1, pending cleared.
    - Else PcEnF=1, PcScrF=00.
    - In every case, return to RUN.
  - StallD=1 while ready: stay in WAIT_MEM with data treated as not yet consumed; the wait counter is frozen.
  - Counter reaching TIMEOUT with ready still low: go to ERROR.
- ERROR:
  - TimeoutErr=1, PcEnF=0, ImemReqF=0, FlushD=1.
  - Exit only by reset.
- Target outputs:
  - While pending is set, PcBranchF/PcJumpF come from the pending target registers.
  - Otherwise they pass PcBranchD/PcJumpD through combinationally.
- No combinational path from ImemReadyF to ImemReqF.
- Latency: a redirect with ready memory updates the PC on the next rising edge (0 bubbles beyond the flushed slot).

Decomposition:
- Shared package:
  - PcScrF codes: PCSEL_PLUS4=2'b00, PCSEL_BRANCH=2'b01, PCSEL_JUMP=2'b10.
  - State encoding constants.
- One natural sub-module: redirect_latch. It holds the pending flag, select code and 32-bit target with set/overwrite/clear, and produces the target muxing.

Test Plan:
- Reset held 3 cycles, then released with ImemReadyF=1 → PcEnF=0 for 4 cycles, then PcEnF=1, PcScrF=00 every cycle; ImemReqF rises at cycle 4.
- RUN with ready, BranchTakenD=1, PcBranchD=0x40 for 1 cycle → the same cycle shows PcEnF=1, PcScrF=01, FlushD=1, PcBranchF=0x40; the next cycle shows PcScrF=00.
- ImemReadyF=0 for 5 cycles; JumpD=1, PcJumpD=0x100 in wait cycle 2, then D inputs change to 0 → on ready: PcScrF=10, PcJumpF=0x100, PcEnF=1, pending cleared.
- BranchTakenD and JumpD both 1 in RUN → PcScrF=10.
- StallD=1 with BranchTakenD=1 → PcEnF=0, FlushD=0, PcScrF=00, nothing latched.
- ImemReadyF held 0 for 255 cycles → TimeoutErr=1 sticky, ImemReqF=0; assert Reset=0 → TimeoutErr=0, state BOOT.
